// File: rtl/period_meter_if.sv
// Event/result bus of the period meter: event input, synchronous clear and the
// valid/ready result channel with its sticky lost flag.
interface period_meter_if #(
  parameter int CMAX = 1000
);
  localparam int CBIT = $clog2(CMAX + 1);

  logic            evt;
  logic            clr;
  logic            ready;
  logic [CBIT-1:0] period;
  logic            ovf;
  logic            valid;
  logic            lost;

  modport slave  (input  evt, clr, ready, output period, ovf, valid, lost);
  modport master (output evt, clr, ready, input  period, ovf, valid, lost);
endinterface

// File: rtl/period_meter.sv
// Measures clk cycles between rising edges of evt, reporting timeouts at CMAX.
// Define PERIOD_METER_SYNC_EN to pass evt through a two-flop synchronizer first.
module period_meter #(
  parameter int CMAX = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  period_meter_if.slave bus
);
  localparam int              CBIT   = $clog2(CMAX + 1);
  localparam logic [CBIT-1:0] CMAX_C = CBIT'(CMAX);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CBIT-1:0] cnt_q, cnt_d;
  logic            evt_s, evt_q, evt_edge;

  logic            res_v;
  logic [CBIT-1:0] res_per;
  logic            res_ovf;

  logic [CBIT-1:0] period_q, period_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic            lost_q, lost_d;

`ifdef PERIOD_METER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], bus.evt};
  end
  assign evt_s = sync_q[1];
`else
  assign evt_s = bus.evt;
`endif

  // evt_q follows evt_s even during clr so no false edge follows the clear.
  assign evt_edge = evt_s & ~evt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_s;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_v   = 1'b0;
    res_per = cnt_q;
    res_ovf = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (evt_edge) begin
            state_d = RUN;
            cnt_d   = CBIT'(1);
          end
        end
        RUN: begin
          // An edge landing on cnt == CMAX is a valid period, not a timeout.
          if (evt_edge) begin
            res_v = 1'b1;
            cnt_d = CBIT'(1);
          end else if (cnt_q == CMAX_C) begin
            res_v   = 1'b1;
            res_ovf = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CBIT'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    lost_d   = lost_q;
    if (bus.clr) begin
      valid_d = 1'b0;
      lost_d  = 1'b0;
    end else if (res_v) begin
      if (valid_q && !bus.ready) begin
        lost_d = 1'b1;
      end else begin
        period_d = res_per;
        ovf_d    = res_ovf;
        valid_d  = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.period = period_q;
  assign bus.ovf    = ovf_q;
  assign bus.valid  = valid_q;
  assign bus.lost   = lost_q;
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CMAX, default c_ms(1000): maximum measurable interval in clk cycles; CMAX >= 2.
REQ-002 Localparam CBIT = cbit(CMAX): width of count and result.
REQ-003 One clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 evt  input  1  event level; each rising edge marks an event.
REQ-007 clr  input  1  synchronous clear, abandons measurement and any pending result.
REQ-008 period  output  CBIT  measured interval in clk cycles between consecutive events.
REQ-009 ovf  output  1  qualifies period: 1 = timeout result (no second event within CMAX).
REQ-010 valid  output  1  period/ovf hold a result not yet accepted.
REQ-011 ready  input  1  consumer accepts result when valid && ready.
REQ-012 lost  output  1  sticky; a result was discarded because the previous one was still pending.

Function
REQ-013 Edge detect: register evt into evt_q; edge = evt && !evt_q; evt_q reset value 0.
REQ-014 States IDLE (waiting for first event) and RUN (counting since last event); reset state IDLE.
REQ-015 IDLE: cnt held at 0; on edge, go to RUN with cnt <= 1.
REQ-016 RUN, edge: produce result period = cnt, ovf = 0; cnt <= 1; stay RUN.
REQ-017 RUN, no edge, cnt < CMAX: cnt <= cnt + 1.
REQ-018 RUN, no edge, cnt == CMAX: produce result period = CMAX, ovf = 1; cnt <= 0; go to IDLE.
REQ-019 Edge coinciding with cnt == CMAX is an event (REQ-016), not a timeout; period = CMAX, ovf = 0.
REQ-020 Counter never exceeds CMAX and never wraps.
REQ-021 Result produced in cycle t is visible on period/ovf/valid in cycle t+1 (one-cycle latency).
REQ-022 Handshake: valid rises when a result is loaded, falls only on a cycle with valid && ready and no new result.
REQ-023 Result produced while valid && !ready: new result discarded, period/ovf unchanged, lost <= 1.
REQ-024 Result produced in same cycle as valid && ready: new result loaded, valid stays 1, lost unchanged.
REQ-025 period/ovf stable while valid && !ready.
REQ-026 clr has priority over all events: state IDLE, cnt 0, valid 0, lost 0, evt_q <= evt (no false edge on the clr cycle).
REQ-027 Minimum reportable period is 2 (evt must be low at least one cycle between events).

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, cnt 0, evt_q 0, period 0, ovf 0, valid 0, lost 0.
REQ-029 Reset mid-measurement or with a pending result discards everything; no result follows reset release.
REQ-030 First edge after reset release only arms (IDLE -> RUN), never produces a result.

Configuration
REQ-031 Macro PERIOD_METER_SYNC_EN: when defined, evt passes a two-flop synchronizer (reset 0) before edge detect, adding 2 cycles latency to event detection; measured periods unchanged.
REQ-032 Without PERIOD_METER_SYNC_EN, evt feeds edge detect directly; evt must be synchronous to clk.

Verification (CMAX = 8, ready = 1 unless stated)
REQ-033 Edges at cycles 10 and 15 -> one result period = 5, ovf = 0, valid for one cycle at 16.
REQ-034 Edge at cycle 10, no further edges -> result period = 8, ovf = 1 at cycle 19; state IDLE; next edge produces no result.
REQ-035 ready = 0, edges at 10, 13, 17 -> period = 3 held with valid = 1; lost = 1 from cycle 18; period still 3.
REQ-036 Edges at 10, 14, 18 with ready pulsed at cycle 18 -> period 4 accepted, period 4 (second) loaded at 19, valid continuous.
REQ-037 clr asserted at cycle 12 after edge at 10, evt held high -> no result; next rising edge only arms.
REQ-038 rst_n pulsed low mid-count with valid = 1 -> all outputs 0 immediately; with PERIOD_METER_SYNC_EN, REQ-033 repeats with result at cycle 18.
